// File: rtl/clk_divider_scan.sv
// clk_divider_scan
//   Runtime-programmable clock divider with a digit-scan sequencer for a
//   multiplexed 7-segment display. A divide counter runs from 0 up to the
//   active terminal count. Each terminal cycle produces a registered tick,
//   either toggles clk_out (toggle mode) or strobes it for one cycle (pulse
//   mode), and advances the digit select. The digit select drives an
//   active-low one-hot anode enable.
//
// Ports
//   clk_in     : board clock; all state updates on its rising edge
//   rst        : asynchronous active-high reset
//   en         : count enable
//   mode       : 0 = toggle (50% duty clk_out), 1 = pulse (one-cycle strobe)
//   div_in     : new terminal count value
//   div_load   : one-cycle strobe that captures div_in
//   clk_out    : divided clock or strobe
//   tick       : one-cycle pulse in the cycle after each terminal cycle
//   digit_sel  : current digit index
//   an_n       : active-low one-hot anode enable, ~(1 << digit_sel)
//   div_active : terminal count currently in use
module clk_divider_scan #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2499,
  parameter int N_DIGITS    = 4,
  localparam int SEL_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [CNT_W-1:0]    div_in,
  input  logic                div_load,
  output logic                clk_out,
  output logic                tick,
  output logic [SEL_W-1:0]    digit_sel,
  output logic [N_DIGITS-1:0] an_n,
  output logic [CNT_W-1:0]    div_active
);

  localparam logic [SEL_W-1:0]    LAST_SEL  = SEL_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0]    RESET_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [N_DIGITS-1:0] RESET_AN  = ~N_DIGITS'(1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                clk_out_q, clk_out_d;
  logic                tick_q, tick_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [CNT_W-1:0]    div_active_q, div_active_d;
  logic [CNT_W-1:0]    div_pend_q, div_pend_d;
  logic                pend_q, pend_d;
  logic                term;

  always_comb begin
    term         = en && (cnt_q == div_active_q);
    cnt_d        = cnt_q;
    clk_out_d    = clk_out_q;
    tick_d       = 1'b0;
    sel_d        = sel_q;
    div_active_d = div_active_q;
    div_pend_d   = div_pend_q;
    pend_d       = pend_q;

    if (term) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      clk_out_d = mode ? 1'b1 : ~clk_out_q;
      sel_d     = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
      // The terminal cycle itself used the old value; the new one takes
      // over for the next period. A same-cycle load beats a pending one.
      if (div_load) begin
        div_active_d = div_in;
      end else if (pend_q) begin
        div_active_d = div_pend_q;
      end
      pend_d = 1'b0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (mode) begin
        clk_out_d = 1'b0;
      end
      // Defer mid-period loads so a shrunken terminal can never be skipped.
      if (div_load) begin
        div_pend_d = div_in;
        pend_d     = 1'b1;
      end
    end else begin
      if (mode) begin
        clk_out_d = 1'b0;
      end
      // While stopped there is no period to protect: apply at once and
      // restart the count so it cannot sit above the new terminal.
      if (div_load) begin
        div_active_d = div_in;
        cnt_d        = '0;
        pend_d       = 1'b0;
      end else if (pend_q) begin
        div_active_d = div_pend_q;
        cnt_d        = '0;
        pend_d       = 1'b0;
      end
    end

    // Derived from the next select so anode and index change together.
    an_d = ~(N_DIGITS'(1) << sel_d);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      clk_out_q    <= 1'b0;
      tick_q       <= 1'b0;
      sel_q        <= '0;
      an_q         <= RESET_AN;
      div_active_q <= RESET_DIV;
      div_pend_q   <= '0;
      pend_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      clk_out_q    <= clk_out_d;
      tick_q       <= tick_d;
      sel_q        <= sel_d;
      an_q         <= an_d;
      div_active_q <= div_active_d;
      div_pend_q   <= div_pend_d;
      pend_q       <= pend_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign digit_sel  = sel_q;
  assign an_n       = an_q;
  assign div_active = div_active_q;

endmodule
